// File: rtl/sipo_word_fifo.sv
// First-word-fall-through word FIFO behind the serial-to-parallel packer.
// Words arriving while full are dropped and latched into a sticky overflow flag.
module sipo_word_fifo #(
   parameter  int DATA_WIDTH  = 64,
   parameter  int DEPTH       = 4,
   localparam int COUNT_WIDTH = $clog2(DEPTH) + 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic [DATA_WIDTH-1:0]  in_data,
   input  logic                   flush,
   output logic                   out_valid,
   output logic [DATA_WIDTH-1:0]  out_data,
   input  logic                   out_ready,
   output logic                   full,
   output logic                   empty,
   output logic [COUNT_WIDTH-1:0] count,
   output logic                   overflow
);

   localparam int PTR_WIDTH = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
   logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   overflow_q, overflow_d;
   logic                   push, pop, drop, mem_we;

   assign full      = (count_q == COUNT_WIDTH'(DEPTH));
   assign empty     = (count_q == '0);
   assign out_valid = !empty;
   assign out_data  = mem_q[rd_ptr_q];
   assign count     = count_q;
   assign overflow  = overflow_q;

   assign pop  = out_valid && out_ready;
   assign push = in_valid && (!full || pop);
   assign drop = in_valid && full && !pop;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      mem_we     = 1'b0;
      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
      end else begin
         if (push) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
         end
         if (push && !pop) begin
            count_d = count_q + COUNT_WIDTH'(1);
         end else if (pop && !push) begin
            count_d = count_q - COUNT_WIDTH'(1);
         end
         if (drop) begin
            overflow_d = 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // NOTE: the word array is reset so out_data reads 0 after reset; flush deliberately leaves it alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (mem_we) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

endmodule

// File: doc/sipo_word_fifo.md
# sipo_word_fifo

Word buffer that sits directly downstream of the serial-to-parallel packer. It captures each assembled wide word on the packer's one-cycle `out_valid` pulse and stores it in a small first-word-fall-through FIFO. Words are presented to the consumer (buffer write port / PE feeder) through a valid/ready handshake, which decouples the packer, which can never stall, from a consumer that can. Words that arrive while the FIFO is full are dropped and flagged by a sticky overflow bit.

## Interface
- `DATA_WIDTH`, 64: wide word width; equals the packer's output width.
- `DEPTH`, 4: number of word entries; power of two, ≥ 2.
- `COUNT_WIDTH`, `C_LOG_2(DEPTH)+1`: occupancy counter width (derived, not overridden).

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  write strobe; connects to the packer's `out_valid`.
- `in_data`  in  DATA_WIDTH  word to store; connects to the packer's `data_out`.
- `flush`  in  1  synchronous clear of contents and overflow flag.
- `out_valid`  out  1  head word is available.
- `out_data`  out  DATA_WIDTH  head word.
- `out_ready`  in  1  consumer accepts the head word this cycle.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `count`  out  COUNT_WIDTH  occupancy, 0..DEPTH.
- `overflow`  out  1  sticky flag: at least one word was dropped.

## Operation
- Storage is a DEPTH × DATA_WIDTH register array.
- `wr_ptr` and `rd_ptr` are each `C_LOG_2(DEPTH)` bits and wrap naturally modulo DEPTH.
- Derived signals:
  - pop = `out_valid && out_ready`
  - push = `in_valid && (!full || pop)`
  - drop = `in_valid && full && !pop`
- On push: `mem[wr_ptr] <= in_data`, then `wr_ptr` increments.
- On pop: `rd_ptr` increments.
- Count update:
  - push && !pop: +1
  - pop && !push: −1
  - both or neither: unchanged
- Full with simultaneous pop and write: the write is accepted, `count` stays DEPTH, and no overflow is raised.
- Empty with `in_valid`: the word is written. No same-cycle bypass; `out_valid` stays 0 in that cycle.
- `out_valid` is `!empty`.
- `out_data` is `mem[rd_ptr]`, combinational from registered state (first-word fall-through). When empty it shows a stale entry; consumers ignore it.
- Overflow:
  - drop sets `overflow` to 1, and the word is discarded.
  - `wr_ptr`, `count` and memory are unchanged.
  - `overflow` holds until `flush` or reset.
- `flush` has priority over push, pop and drop in the same cycle. It sets `wr_ptr`, `rd_ptr` and `count` to 0 and `overflow` to 0. A coincident `in_valid` word is discarded and does not set overflow. Memory contents are not cleared.
- Reset (asynchronous, any time, including mid-transfer):
  - pointers, `count` and memory cleared to 0
  - `out_valid`=0, `out_data`=0, `empty`=1, `full`=0, `overflow`=0
- `out_ready` while empty is legal and has no effect.
- No state machine beyond pointer/count state. `full`, `empty` and `out_valid` are decodes of `count`.

## Timing
- Write latency: a word with `in_valid` high in cycle N appears as `out_valid`=1 / `out_data` in cycle N+1 when the FIFO was empty.
- Pop takes effect at the edge where `out_valid && out_ready`. The next entry, or `out_valid`=0, is visible the following cycle.
- Throughput: one push and one pop per cycle sustained. The packer pulses at most once per NUM_SHIFTS cycles, so with DEPTH ≥ 2 no overflow occurs while the consumer keeps `out_ready` high.
- `count`, `full` and `empty` reflect state after the most recent edge. There are no combinational paths from `in_valid` or `out_ready` to any output.
- Flush takes effect at the next edge. All outputs show the cleared state in the following cycle.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-stream with 2 words held → outputs immediately `out_valid`=0, `count`=0, `empty`=1, `overflow`=0, `out_data`=0.
- **Fill and drain order:** `out_ready`=0, push 0x11…11, 0x22…22, 0x33…33, 0x44…44 → `full`=1, `count`=4. Then `out_ready`=1 → words read in the same order, one per cycle, then `empty`=1.
- **Overflow:** FIFO full, `out_ready`=0, push 0x55…55 → `overflow`=1, `count`=4. Drain reads 0x11…11–0x44…44 only. `overflow` stays 1 until a `flush` pulse, then returns to 0.
- **Full with simultaneous push and pop:** FIFO full, `out_ready`=1, push 0x66…66 → `count` stays 4, `overflow`=0, and 0x66…66 is read last.
- **Pointer wrap:** random `out_ready` with 50 packer pulses at a 4-cycle spacing → all 50 words out in order with none lost, `count` never exceeds 4, `overflow`=0.
- **Flush with coincident write:** FIFO holds 2 words, `flush`=1 together with `in_valid`=1 → next cycle `count`=0, `empty`=1, `overflow`=0, and the coincident word is never output.
